// File: rtl/poly_decompose_pipe.sv
// poly_decompose_pipe: 3-stage, divider-free decomposition a -> (r1, r0) of LANES coefficients per beat.
// Define DECOMPOSE_RANGE_CHK_EN to flag (and zero) lanes whose input is >= q.
module poly_decompose_pipe #(
    parameter int LANES = 2,
    parameter int QW    = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*QW-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*20-1:0] out_r0,
    output logic [LANES*6-1:0]  out_r1,
    output logic [LANES-1:0]    out_err
);
    localparam longint unsigned ALPHA0 = 64'd190464;
    localparam longint unsigned ALPHA1 = 64'd523776;
    localparam logic [QW-1:0] TH0 = QW'(23'd8285185);
    localparam logic [QW-1:0] TH1 = QW'(23'd8118529);

    localparam logic [21:0] H0_1 = 22'd95232;
    localparam logic [21:0] H0_3 = 22'd285696;
    localparam logic [21:0] H0_5 = 22'd476160;
    localparam logic [21:0] H1_1 = 22'd261888;
    localparam logic [21:0] H1_3 = 22'd785664;
    localparam logic [21:0] H1_5 = 22'd1309440;
    localparam logic [21:0] A0_1 = 22'd190464;
    localparam logic [21:0] A0_2 = 22'd380928;
    localparam logic [21:0] A0_3 = 22'd571392;
    localparam logic [21:0] A1_1 = 22'd523776;
    localparam logic [21:0] A1_2 = 22'd1047552;
    localparam logic [21:0] A1_3 = 22'd1571328;

    // Constant table {quotient, residue} of (v << pos) by alpha; every entry folds at elaboration.
    function automatic logic [25:0] grp_lut(input logic m, input logic [3:0] v, input int pos);
        logic [25:0]     res;
        longint unsigned p;
        res = 26'd0;
        for (int k = 0; k < 16; k++) begin
            p   = 64'(k) << pos;
            res = (int'(v) == k) ? (m ? {6'(p / ALPHA1), 20'(p % ALPHA1)}
                                      : {6'(p / ALPHA0), 20'(p % ALPHA0)}) : res;
        end
        return res;
    endfunction

    // Returns {hi1, hi0, quotient_sum[5:0], residue_sum[21:0]}; residue_sum < 3*alpha + 4096.
    function automatic logic [29:0] s1_calc(input logic m, input logic [QW-1:0] a);
        logic [25:0] g0;
        logic [25:0] g1;
        logic [25:0] g2;
        logic [21:0] sum;
        logic [5:0]  qs;
        g0  = grp_lut(m, a[15:12], 12);
        g1  = grp_lut(m, a[19:16], 16);
        g2  = grp_lut(m, {1'b0, a[22:20]}, 20);
        sum = {10'd0, a[11:0]} + {2'd0, g0[19:0]} + {2'd0, g1[19:0]} + {2'd0, g2[19:0]};
        qs  = g0[25:20] + g1[25:20] + g2[25:20];
        return {(a >= TH1), (a >= TH0), qs, sum};
    endfunction

    // Centred reduction: k = number of half-odd multiples of alpha below sum; returns {q, r0'}.
    function automatic logic [25:0] s2_calc(input logic m, input logic [21:0] sum, input logic [5:0] qs);
        logic [1:0]  k;
        logic [21:0] sub;
        if (sum > (m ? H1_5 : H0_5)) begin
            k = 2'd3;
        end else if (sum > (m ? H1_3 : H0_3)) begin
            k = 2'd2;
        end else if (sum > (m ? H1_1 : H0_1)) begin
            k = 2'd1;
        end else begin
            k = 2'd0;
        end
        case (k)
            2'd1:    sub = m ? A1_1 : A0_1;
            2'd2:    sub = m ? A1_2 : A0_2;
            2'd3:    sub = m ? A1_3 : A0_3;
            default: sub = 22'd0;
        endcase
        return {qs + {4'd0, k}, 20'(sum - sub)};
    endfunction

    logic             r_v1, r_v2, r_v3;
    logic             r_s1_mode, r_s2_mode;
    logic [21:0]      r_s1_sum [LANES];
    logic [5:0]       r_s1_q   [LANES];
    logic [LANES-1:0] r_s1_hi0, r_s1_hi1;
    logic [19:0]      r_s2_r0  [LANES];
    logic [5:0]       r_s2_q   [LANES];
    logic [LANES-1:0] r_s2_hi0, r_s2_hi1;
    logic [19:0]      r_s3_r0  [LANES];
    logic [5:0]       r_s3_r1  [LANES];

    logic             w_adv1, w_adv2, w_adv3;
    logic [29:0]      w_s1_pack [LANES];
    logic [25:0]      w_s2_pack [LANES];
    logic [19:0]      w_s3_r0   [LANES];
    logic [5:0]       w_s3_r1   [LANES];
    logic [LANES-1:0] w_s3_sp;
    logic [LANES-1:0] w_lane_ok;

    // Each stage moves when the next one is empty or moving itself.
    always_comb begin
        w_adv3   = !r_v3 || out_ready;
        w_adv2   = !r_v2 || w_adv3;
        w_adv1   = !r_v1 || w_adv2;
        in_ready = w_adv1;
    end

    // Per-lane combinational stage logic.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_s1_pack[i] = s1_calc(mode, in_data[i*QW +: QW]);
            w_s2_pack[i] = s2_calc(r_s1_mode, r_s1_sum[i], r_s1_q[i]);
            w_s3_r0[i]   = w_s3_sp[i] ? (r_s2_r0[i] - 20'd1) : r_s2_r0[i];
            w_s3_r1[i]   = w_s3_sp[i] ? 6'd0 : r_s2_q[i];
        end
    end

    assign w_s3_sp = r_s2_mode ? r_s2_hi1 : r_s2_hi0;

`ifdef DECOMPOSE_RANGE_CHK_EN
    localparam logic [QW-1:0] Q_MOD = QW'(24'd8380417);
    logic [LANES-1:0] r_s1_err, r_s2_err, r_s3_err;
    logic [LANES-1:0] w_s1_err;

    // Out-of-range lanes are detected at the input and carried alongside the data.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_s1_err[i] = (in_data[i*QW +: QW] >= Q_MOD);
        end
    end

    assign w_lane_ok = {LANES{r_v2}} & ~r_s2_err;
    assign out_err   = r_s3_err;

    // Error flag pipeline, kept in step with the data stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_err <= {LANES{1'b0}};
            r_s2_err <= {LANES{1'b0}};
            r_s3_err <= {LANES{1'b0}};
        end else begin
            if (w_adv1) r_s1_err <= w_s1_err;
            if (w_adv2) r_s2_err <= r_s1_err;
            if (w_adv3) r_s3_err <= {LANES{r_v2}} & r_s2_err;
        end
    end
`else
    assign w_lane_ok = {LANES{r_v2}};
    assign out_err   = {LANES{1'b0}};
`endif

    // S1: register lookup sums, quotient sums and special-case threshold hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_s1_mode <= 1'b0;
            r_s1_hi0  <= {LANES{1'b0}};
            r_s1_hi1  <= {LANES{1'b0}};
            for (int i = 0; i < LANES; i++) begin
                r_s1_sum[i] <= 22'd0;
                r_s1_q[i]   <= 6'd0;
            end
        end else if (w_adv1) begin
            r_v1      <= in_valid;
            r_s1_mode <= mode;
            for (int i = 0; i < LANES; i++) begin
                r_s1_sum[i] <= w_s1_pack[i][21:0];
                r_s1_q[i]   <= w_s1_pack[i][27:22];
                r_s1_hi0[i] <= w_s1_pack[i][28];
                r_s1_hi1[i] <= w_s1_pack[i][29];
            end
        end
    end

    // S2: register the centred remainder and full quotient.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2      <= 1'b0;
            r_s2_mode <= 1'b0;
            r_s2_hi0  <= {LANES{1'b0}};
            r_s2_hi1  <= {LANES{1'b0}};
            for (int i = 0; i < LANES; i++) begin
                r_s2_r0[i] <= 20'd0;
                r_s2_q[i]  <= 6'd0;
            end
        end else if (w_adv2) begin
            r_v2      <= r_v1;
            r_s2_mode <= r_s1_mode;
            r_s2_hi0  <= r_s1_hi0;
            r_s2_hi1  <= r_s1_hi1;
            for (int i = 0; i < LANES; i++) begin
                r_s2_r0[i] <= w_s2_pack[i][19:0];
                r_s2_q[i]  <= w_s2_pack[i][25:20];
            end
        end
    end

    // S3: output registers; data is zeroed whenever no valid beat is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v3 <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_s3_r0[i] <= 20'd0;
                r_s3_r1[i] <= 6'd0;
            end
        end else if (w_adv3) begin
            r_v3 <= r_v2;
            for (int i = 0; i < LANES; i++) begin
                r_s3_r0[i] <= w_lane_ok[i] ? w_s3_r0[i] : 20'd0;
                r_s3_r1[i] <= w_lane_ok[i] ? w_s3_r1[i] : 6'd0;
            end
        end
    end

    // Flatten the lane registers onto the output buses.
    always_comb begin
        out_valid = r_v3;
        for (int i = 0; i < LANES; i++) begin
            out_r0[i*20 +: 20] = r_s3_r0[i];
            out_r1[i*6 +: 6]   = r_s3_r1[i];
        end
    end
endmodule

// File: doc/poly_decompose_pipe.md
POLY_DECOMPOSE_PIPE -- requirements
Module: poly_decompose_pipe

Interface
REQ-001 Parameter LANES, default 2: coefficients processed per beat, 1..8.
REQ-002 Parameter QW, default 24: coefficient width, >= 23.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 mode  input  1  0: alpha=(q-1)/44=190464; 1: alpha=(q-1)/16=523776; sampled per beat with in_data.
REQ-006 in_valid  input  1  in_data/mode valid.
REQ-007 in_ready  output  1  block accepts beat when in_valid && in_ready.
REQ-008 in_data  input  LANES*QW  lane i at bits [i*QW +: QW], unsigned, expected 0..q-1, q=8380417.
REQ-009 out_valid  output  1  out_r0/out_r1/out_err valid.
REQ-010 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-011 out_r0  output  LANES*20  lane i low part, 20-bit two's complement.
REQ-012 out_r1  output  LANES*6  lane i high part, unsigned 0..43.
REQ-013 out_err  output  LANES  lane i input out of range.

Function
REQ-014 Per lane: r0' = a mod± alpha, range (-alpha/2, alpha/2]; if a - r0' == q-1 then r1=0, r0=r0'-1; else r1=(a-r0')/alpha, r0=r0'.
REQ-015 Special-case thresholds: mode 0 a >= 8285185; mode 1 a >= 8118529.
REQ-016 Reduction SHALL use no divider: high bits via lookup of alpha-residue/quotient per bit-group, low bits by conditional subtract, then centring compare against alpha/2 and 3*alpha/2.
REQ-017 Pipeline: exactly 3 register stages (S1 lookup/sum, S2 centre/quotient, S3 special-case/output); latency 3 cycles from accepted beat to out_valid with out_ready held high.
REQ-018 Each stage carries its own valid bit and the beat's mode; mode changes between consecutive beats SHALL be honoured per beat with no bubble.
REQ-019 Stage k advances when its successor is empty or advancing; S3 advances when out_ready high or S3 empty.
REQ-020 in_ready = S1 empty or S1 advancing; combinational from out_ready permitted.
REQ-021 Full throughput: one beat per cycle when out_ready constantly high.
REQ-022 Backpressure: out_* SHALL hold stable while out_valid && !out_ready; no beat lost, duplicated or reordered.
REQ-023 Pipeline holds at most 3 beats; with out_ready low, in_ready deasserts after third accepted beat.
REQ-024 Simultaneous accept at input and output of a full pipeline SHALL proceed without stall.
REQ-025 Lanes are independent; all lanes of one beat emerge together.
REQ-026 r1 width 6 covers mode 0 max 43; mode 1 max 15, upper bits zero.

Reset
REQ-027 rst high at clock edge clears all stage valids; out_valid=0, out_r0=0, out_r1=0, out_err=0 after that edge.
REQ-028 Reset mid-operation discards in-flight beats; in_ready=1 first cycle after rst deasserts.
REQ-029 Datapath registers may be left unreset only if outputs are gated to 0 when out_valid=0.

Configuration
REQ-030 Macro DECOMPOSE_RANGE_CHK_EN.
REQ-031 Defined: lane with a >= q sets out_err=1 and forces that lane's r0=0, r1=0; other lanes unaffected.
REQ-032 Undefined: out_err tied 0, no comparator synthesised; out-of-range inputs give unspecified r0/r1.

Verification
REQ-033 mode 0, a=0, 95232, 95233 -> (r0,r1) = (0,0), (95232,0), (-95231,1), 3 cycles after accept.
REQ-034 mode 0, a=8285185 -> (-95232,0); a=8380416 -> (-1,0); mode 1, a=8380416 -> (-1,0); a=261889 -> (-261887,1).
REQ-035 Alternating mode every beat, 1000 random a per lane, out_ready=1 -> matches golden model, one result per cycle.
REQ-036 Continuous input, out_ready low 5 cycles -> in_ready low after 3 accepts, outputs stable, all results in order once released.
REQ-037 rst pulsed with 3 beats in flight -> out_valid=0 next cycle, no stale beat emitted afterwards.
REQ-038 With DECOMPOSE_RANGE_CHK_EN, lane0 a=8380417, lane1 a=1 mode 0 -> lane0 err=1 (0,0), lane1 err=0 (1,0).
